tri_dispatch_sched: RTL and testbench
=====================================

# tri_dispatch_sched

Round-robin scheduler between the triangle assembler and a bank of rasterizer lanes. It captures each assembled 168-bit triangle (three vertices plus color) into a one-entry holding register and issues it to the next free lane. It tracks frame boundaries: on end-of-frame it drains all lanes, then reports frame completion and the per-frame triangle count. It sits between the AHB-fed assembler and the raster back end.

## Interface
- NUM_LANES, 4, number of rasterizer lanes (2..8)
- CNT_W, 16, width of triangle counters
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- texel_ready  in  1  assembler has a complete triangle on texel_buffer
- texel_buffer  in  168  assembled triangle
- texel_read  out  1  one-cycle pulse: triangle captured this cycle
- frame_end  in  1  one-cycle pulse: last triangle of frame already presented
- lane_ready  in  NUM_LANES  lane i can accept a triangle this cycle
- lane_valid  out  NUM_LANES  one-hot issue strobe, one cycle
- lane_triangle  out  168  triangle bus shared by all lanes, qualified by lane_valid
- frame_done  out  1  one-cycle pulse: frame fully drained
- frame_tri_count  out  CNT_W  triangles dispatched in last completed frame
- busy  out  1  state is not IDLE

## Operation
- States: IDLE (hold empty), HOLD (hold full), DRAIN (end-of-frame, waiting for lanes), DONE (frame_done pulse).
- IDLE: when texel_ready=1, capture texel_buffer, pulse texel_read, go to HOLD.
- HOLD: when any lane_ready bit is 1, the arbiter grants one lane. lane_valid[g]=1 and lane_triangle=hold for that cycle; the transfer completes that cycle.
- After a dispatch: if end_pending, go to DRAIN. Else if texel_ready=1, capture the next triangle in the same cycle (back-to-back), pulse texel_read and stay in HOLD. Otherwise go to IDLE.
- Arbitration: round-robin. Search starts at lane (last_grant+1) mod NUM_LANES. last_grant resets to NUM_LANES-1, so the first grant goes to lane 0. last_grant updates only on an actual issue.
- frame_end handling:
  - IDLE: go straight to DRAIN.
  - HOLD: set end_pending; go to DRAIN after the held triangle dispatches.
  - frame_end in the same cycle as a capture: the captured triangle belongs to the ending frame.
- DRAIN: texel_read is held at 0. Wait until lane_ready is all-ones, then go to DONE.
- DONE: pulse frame_done, load frame_tri_count with cur_count, clear cur_count and end_pending, go to IDLE.
- cur_count increments on each issue and saturates at 2^CNT_W-1.
- A frame with zero triangles is legal: frame_done pulses and frame_tri_count=0.
- frame_end while in DRAIN or DONE is ignored.
- Reset mid-operation discards the held triangle and end_pending; no partial issue.

## Timing
- Reset values: texel_read=0, lane_valid=0, lane_triangle=0, frame_done=0, frame_tri_count=0, busy=0, state=IDLE.
- Capture to earliest issue: 1 cycle (capture at edge N, lane_valid high in cycle N+1).
- Sustained throughput is 1 triangle/cycle when texel_ready stays high and a lane is ready each cycle.
- lane_valid and texel_read are registered outputs. lane_triangle is the holding register and is stable while in HOLD.
- Drain: DONE is entered 1 cycle after lane_ready is first all-ones in DRAIN. frame_done is high for exactly that DONE cycle.
- Simultaneous issue and capture: the bus shows the old triangle while the register loads the new one at the edge.

## Configuration
- TRI_DISPATCH_STATS_EN defined:
  - Adds output lane_tri_count, width NUM_LANES*CNT_W, packed with lane i at bits [i*CNT_W +: CNT_W].
  - Per-lane count of issued triangles in the current frame, saturating.
  - Snapshotted on DONE, reset to 0.
- Not defined: the port and counters are absent; all other behaviour is identical.

## Structure
- Package tri_dispatch_pkg:
  - TRI_W=168.
  - Enum disp_state_t {IDLE, HOLD, DRAIN, DONE}.
  - Triangle typedef tri_t (logic [TRI_W-1:0]).
- Sub-module rr_arbiter:
  - Parameter NUM_LANES.
  - Inputs req, last_grant, en.
  - Outputs one-hot grant and grant_idx.
  - Purely combinational; last_grant is registered in the parent.

## Test plan
- Single triangle, texel_buffer=168'hA5…, lane_ready=4'b1111:
  - texel_read pulses at cycle N; lane_valid=4'b0001 at N+1 with lane_triangle=A5…
  - then frame_end gives frame_done two cycles later with frame_tri_count=1.
- Six back-to-back triangles, all lanes ready -> lane_valid sequence 0001,0010,0100,1000,0001,0010; one issue per cycle.
- lane_ready=4'b0100 only, three triangles:
  - all three issue on lane 2;
  - texel_read stays 0 while the hold register is full and lane_ready=0.
- frame_end while lane 1 is busy (lane_ready=4'b1101):
  - state stays DRAIN and texel_ready is ignored;
  - lane 1 ready -> frame_done after 1 cycle.
- frame_end with no triangles -> frame_done, frame_tri_count=0.
- n_rst asserted while in HOLD -> all outputs return to their reset values immediately; the next triangle issues to lane 0.

Source files
------------

// File: rtl/tri_dispatch_pkg.sv
// Shared types for the triangle dispatch scheduler: triangle width,
// scheduler state encoding and the triangle bus type.
package tri_dispatch_pkg;

  localparam int TRI_W = 168;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } disp_state_t;

  typedef logic [TRI_W-1:0] tri_t;

endpackage

// File: rtl/tri_dispatch_sched_rr_arbiter.sv
// Combinational round-robin arbiter. The search begins one lane past the
// previous grant and wraps; the grant register itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_LANES = 4,
  localparam int IDX_W = $clog2(NUM_LANES)
) (
  input  logic                 en,
  input  logic [NUM_LANES-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_LANES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // pick the first requesting lane after last_grant, wrapping around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = IDX_W'((int'(last_grant) + 1 + i) % NUM_LANES);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tri_dispatch_sched.sv
// Triangle dispatch scheduler: one-entry holding register feeding a bank of
// rasterizer lanes round-robin, with end-of-frame drain and triangle counts.
// Optional per-lane statistics port enabled by TRI_DISPATCH_STATS_EN.
//
//   state | meaning
//   IDLE  | hold register empty, waiting for a triangle or frame end
//   HOLD  | hold register full, waiting for any ready lane
//   DRAIN | frame ended, waiting for every lane to report ready
//   DONE  | one cycle: frame_done pulse, counts snapshotted and cleared
module tri_dispatch_sched
  import tri_dispatch_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 texel_ready,
  input  tri_t                 texel_buffer,
  output logic                 texel_read,
  input  logic                 frame_end,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic [NUM_LANES-1:0] lane_valid,
  output tri_t                 lane_triangle,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_tri_count,
`ifdef TRI_DISPATCH_STATS_EN
  output logic [NUM_LANES*CNT_W-1:0] lane_tri_count,
`endif
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_LANES);

  disp_state_t          state_q, state_d;
  tri_t                 hold_q, hold_d;
  tri_t                 out_tri_q, out_tri_d;
  logic [NUM_LANES-1:0] lane_valid_q, lane_valid_d;
  logic                 texel_read_q, texel_read_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic                 end_pending_q, end_pending_d;
  logic [CNT_W-1:0]     cur_count_q, cur_count_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [NUM_LANES-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 issue, capture, pend, drain_done;

  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .en         (state_q == HOLD),
    .req        (lane_ready),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // next-state, capture/issue decisions and counter updates
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    out_tri_d     = out_tri_q;
    lane_valid_d  = '0;
    texel_read_d  = 1'b0;
    last_grant_d  = last_grant_q;
    end_pending_d = end_pending_q;
    cur_count_d   = cur_count_q;
    frame_cnt_d   = frame_cnt_q;
    issue         = 1'b0;
    capture       = 1'b0;
    pend          = end_pending_q | frame_end;
    drain_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (texel_ready) begin
          capture       = 1'b1;
          state_d       = HOLD;
          end_pending_d = frame_end;
        end else if (frame_end) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        end_pending_d = pend;
        if (|grant) begin
          issue = 1'b1;
          if (pend)             state_d = DRAIN;
          else if (texel_ready) capture = 1'b1;
          else                  state_d = IDLE;
        end
      end
      DRAIN: begin
        if (&lane_ready) begin
          drain_done  = 1'b1;
          state_d     = DONE;
          frame_cnt_d = cur_count_q;
        end
      end
      DONE: begin
        cur_count_d   = '0;
        end_pending_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      hold_d       = texel_buffer;
      texel_read_d = 1'b1;
    end
    // the output copy keeps the issued triangle on the bus even when the
    // hold register reloads at the same edge
    if (issue) begin
      lane_valid_d = grant;
      out_tri_d    = hold_q;
      last_grant_d = grant_idx;
      if (cur_count_q != '1) cur_count_d = cur_count_q + CNT_W'(1);
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      out_tri_q     <= '0;
      lane_valid_q  <= '0;
      texel_read_q  <= 1'b0;
      last_grant_q  <= IDX_W'(NUM_LANES - 1);
      end_pending_q <= 1'b0;
      cur_count_q   <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      out_tri_q     <= out_tri_d;
      lane_valid_q  <= lane_valid_d;
      texel_read_q  <= texel_read_d;
      last_grant_q  <= last_grant_d;
      end_pending_q <= end_pending_d;
      cur_count_q   <= cur_count_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign texel_read      = texel_read_q;
  assign lane_valid      = lane_valid_q;
  assign lane_triangle   = out_tri_q;
  assign frame_done      = (state_q == DONE);
  assign frame_tri_count = frame_cnt_q;
  assign busy            = (state_q != IDLE);

`ifdef TRI_DISPATCH_STATS_EN
  logic [CNT_W-1:0] lane_cnt_q  [NUM_LANES];
  logic [CNT_W-1:0] lane_cnt_d  [NUM_LANES];
  logic [CNT_W-1:0] lane_snap_q [NUM_LANES];
  logic [CNT_W-1:0] lane_snap_d [NUM_LANES];

  // per-lane saturating counts, snapshotted with the frame count
  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    lane_snap_d = lane_snap_q;
    if (issue && lane_cnt_q[grant_idx] != '1)
      lane_cnt_d[grant_idx] = lane_cnt_q[grant_idx] + CNT_W'(1);
    if (drain_done) lane_snap_d = lane_cnt_q;
    if (state_q == DONE)
      for (int i = 0; i < NUM_LANES; i++) lane_cnt_d[i] = '0;
  end

  // per-lane statistics registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_cnt_q[i]  <= '0;
        lane_snap_q[i] <= '0;
      end
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      lane_snap_q <= lane_snap_d;
    end
  end

  // pack snapshots with lane i at bits [i*CNT_W +: CNT_W]
  always_comb begin
    lane_tri_count = '0;
    for (int i = 0; i < NUM_LANES; i++)
      lane_tri_count[i*CNT_W +: CNT_W] = lane_snap_q[i];
  end
`endif

endmodule

// File: tb/tb_tri_dispatch_sched.sv
// Scoreboard bench for tri_dispatch_sched: stimulus pushes expected issues
// and frame counts, a negedge monitor pops and compares them.
module tb_tri_dispatch_sched;
  import tri_dispatch_pkg::*;

  localparam int NL = 4;
  localparam int CW = 16;

  logic          clk;
  logic          n_rst;
  logic          texel_ready;
  tri_t          texel_buffer;
  logic          texel_read;
  logic          frame_end;
  logic [NL-1:0] lane_ready;
  logic [NL-1:0] lane_valid;
  tri_t          lane_triangle;
  logic          frame_done;
  logic [CW-1:0] frame_tri_count;
  logic          busy;

  tri_dispatch_sched #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .texel_ready     (texel_ready),
    .texel_buffer    (texel_buffer),
    .texel_read      (texel_read),
    .frame_end       (frame_end),
    .lane_ready      (lane_ready),
    .lane_valid      (lane_valid),
    .lane_triangle   (lane_triangle),
    .frame_done      (frame_done),
    .frame_tri_count (frame_tri_count),
    .busy            (busy)
  );

  typedef struct {
    int   lane;
    tri_t data;
  } exp_issue_t;

  exp_issue_t issue_q[$];
  int         frame_q[$];
  int         issue_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [TRI_W-1:0] act, input logic [TRI_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic tri_t pat(input logic [7:0] b);
    return {21{b}};
  endfunction

  // monitor: compare every issue and every frame_done against the queues
  always @(negedge clk) begin
    if (n_rst) begin
      if (lane_valid != '0) begin
        if (issue_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue actual=%b expected=none", lane_valid);
        end else begin
          exp_issue_t e;
          logic [NL-1:0] oh;
          e  = issue_q.pop_front();
          oh = '0;
          oh[e.lane] = 1'b1;
          check("issue_lane", TRI_W'(lane_valid), TRI_W'(oh));
          check("issue_triangle", lane_triangle, e.data);
          issue_cyc.push_back(cyc);
        end
      end
      if (frame_done) begin
        if (frame_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_done actual=%0d expected=none", frame_tri_count);
        end else begin
          int fc;
          fc = frame_q.pop_front();
          check("frame_count", TRI_W'(frame_tri_count), TRI_W'(fc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    texel_ready = 1'b0;
    texel_buffer = '0;
    frame_end = 1'b0;
    lane_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
  endtask

  // present t until the DUT reports it captured (texel_read after the edge)
  task automatic send_one(input tri_t t);
    int n;
    texel_buffer = t;
    texel_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!texel_read && n < 50);
    check("send_captured", TRI_W'(texel_read), TRI_W'(1));
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic wait_issues();
    for (int n = 0; n < 100 && issue_q.size() != 0; n++) tick();
    check("issues_drained", TRI_W'(issue_q.size()), TRI_W'(0));
  endtask

  task automatic wait_frames();
    for (int n = 0; n < 100 && frame_q.size() != 0; n++) tick();
    check("frames_drained", TRI_W'(frame_q.size()), TRI_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0;
    texel_ready = 1'b0;
    texel_buffer = '0;
    frame_end = 1'b0;
    lane_ready = '0;
    #12;
    check("rst_texel_read", TRI_W'(texel_read), TRI_W'(0));
    check("rst_lane_valid", TRI_W'(lane_valid), TRI_W'(0));
    check("rst_lane_triangle", lane_triangle, '0);
    check("rst_frame_done", TRI_W'(frame_done), TRI_W'(0));
    check("rst_frame_count", TRI_W'(frame_tri_count), TRI_W'(0));
    check("rst_busy", TRI_W'(busy), TRI_W'(0));

    // 1: single triangle, exact latency and drain timing
    do_reset();
    issue_q.push_back('{0, pat(8'hA5)});
    send_one(pat(8'hA5));
    texel_ready = 1'b0;
    check("t1_no_issue_at_capture", TRI_W'(lane_valid), TRI_W'(0));
    tick();
    check("t1_lane_valid", TRI_W'(lane_valid), TRI_W'(4'b0001));
    check("t1_lane_triangle", lane_triangle, pat(8'hA5));
    check("t1_texel_read_low", TRI_W'(texel_read), TRI_W'(0));
    frame_q.push_back(1);
    pulse_frame_end();
    check("t1_drain_busy", TRI_W'(busy), TRI_W'(1));
    check("t1_done_not_yet", TRI_W'(frame_done), TRI_W'(0));
    tick();
    check("t1_frame_done", TRI_W'(frame_done), TRI_W'(1));
    check("t1_frame_count", TRI_W'(frame_tri_count), TRI_W'(1));
    tick();
    check("t1_done_pulse_end", TRI_W'(frame_done), TRI_W'(0));
    check("t1_idle", TRI_W'(busy), TRI_W'(0));

    // 2: six back-to-back triangles, all lanes ready
    do_reset();
    issue_cyc.delete();
    begin
      int lanes[6] = '{0, 1, 2, 3, 0, 1};
      for (int k = 0; k < 6; k++) issue_q.push_back('{lanes[k], pat(8'h10 + 8'(k))});
      for (int k = 0; k < 6; k++) send_one(pat(8'h10 + 8'(k)));
    end
    texel_ready = 1'b0;
    wait_issues();
    check("t2_issue_total", TRI_W'(issue_cyc.size()), TRI_W'(6));
    if (issue_cyc.size() == 6)
      check("t2_one_per_cycle", TRI_W'(issue_cyc[5] - issue_cyc[0]), TRI_W'(5));
    frame_q.push_back(6);
    pulse_frame_end();
    wait_frames();

    // 3: only lane 2 ready; stall with full hold register
    do_reset();
    lane_ready = 4'b0000;
    for (int k = 0; k < 3; k++) issue_q.push_back('{2, pat(8'h30 + 8'(k))});
    send_one(pat(8'h30));
    texel_buffer = pat(8'h31);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_stall_texel_read", TRI_W'(texel_read), TRI_W'(0));
      check("t3_stall_lane_valid", TRI_W'(lane_valid), TRI_W'(0));
    end
    lane_ready = 4'b0100;
    send_one(pat(8'h31));
    send_one(pat(8'h32));
    texel_ready = 1'b0;
    wait_issues();
    lane_ready = 4'b1111;
    frame_q.push_back(3);
    pulse_frame_end();
    wait_frames();

    // 5: empty frame
    do_reset();
    frame_q.push_back(0);
    pulse_frame_end();
    wait_frames();

    // 4: drain waits for lane 1; texel_ready and frame_end ignored meanwhile
    do_reset();
    issue_q.push_back('{0, pat(8'h40)});
    send_one(pat(8'h40));
    texel_ready = 1'b0;
    wait_issues();
    lane_ready = 4'b1101;
    frame_q.push_back(1);
    pulse_frame_end();
    texel_buffer = pat(8'h41);
    texel_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frame_end = (k == 1);
      tick();
      check("t4_drain_busy", TRI_W'(busy), TRI_W'(1));
      check("t4_drain_no_done", TRI_W'(frame_done), TRI_W'(0));
      check("t4_drain_no_read", TRI_W'(texel_read), TRI_W'(0));
    end
    frame_end = 1'b0;
    texel_ready = 1'b0;
    lane_ready = 4'b1111;
    tick();
    check("t4_frame_done", TRI_W'(frame_done), TRI_W'(1));
    tick();
    check("t4_done_pulse_end", TRI_W'(frame_done), TRI_W'(0));
    check("t4_idle", TRI_W'(busy), TRI_W'(0));
    repeat (3) tick();
    check("t4_no_second_done", TRI_W'(frame_q.size()), TRI_W'(0));

    // 6: reset while HOLD with end pending
    issue_q.push_back('{1, pat(8'h60)});
    send_one(pat(8'h60));
    texel_ready = 1'b0;
    wait_issues();
    lane_ready = 4'b0000;
    send_one(pat(8'h61));
    texel_ready = 1'b0;
    pulse_frame_end();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_rst_texel_read", TRI_W'(texel_read), TRI_W'(0));
    check("t6_rst_lane_valid", TRI_W'(lane_valid), TRI_W'(0));
    check("t6_rst_lane_triangle", lane_triangle, '0);
    check("t6_rst_frame_done", TRI_W'(frame_done), TRI_W'(0));
    check("t6_rst_frame_count", TRI_W'(frame_tri_count), TRI_W'(0));
    check("t6_rst_busy", TRI_W'(busy), TRI_W'(0));
    lane_ready = 4'b1111;
    tick();
    n_rst = 1'b1;
    tick();
    check("t6_hold_discarded", TRI_W'(busy), TRI_W'(0));
    issue_q.push_back('{0, pat(8'h62)});
    send_one(pat(8'h62));
    texel_ready = 1'b0;
    wait_issues();
    tick();
    check("t6_no_stale_end", TRI_W'(busy), TRI_W'(0));
    frame_q.push_back(1);
    pulse_frame_end();
    wait_frames();

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
